// File: rtl/aes_block_gearbox_pkg.sv
// Shared widths and the gearbox FSM state type for the AES datapath.
package aes_package;

  localparam int AES_WORD_W          = 32;
  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_gearbox_state_t;

endpackage

// File: rtl/aes_block_serializer.sv
// Unpack path: holds one ciphertext block from the AES core and emits it
// as four words, most significant word first. Pulses block_done when the
// last word of the held block is accepted downstream.
module aes_block_serializer
  import aes_package::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               flush,
  input  logic               accept_en,
  input  logic               res_valid_i,
  output logic               res_ready_o,
  input  logic [BLOCK_W-1:0] res_data_i,
  output logic               ct_valid_o,
  input  logic               ct_ready_i,
  output logic [WORD_W-1:0]  ct_data_o,
  output logic               block_done_o
);

  logic [BLOCK_W-1:0] res_q;
  logic [1:0]         ct_idx_q;
  logic               res_full_q;
  logic               res_hs;
  logic               ct_hs;

  assign res_ready_o  = accept_en & ~res_full_q;
  assign ct_valid_o   = res_full_q;
  assign res_hs       = res_valid_i & res_ready_o;
  assign ct_hs        = res_full_q & ct_ready_i;
  assign block_done_o = ct_hs & (ct_idx_q == 2'(AES_WORDS_PER_BLOCK - 1));

  // Select the current outgoing word; index 0 is the most significant word.
  always_comb begin
    ct_data_o = '0;
    unique case (ct_idx_q)
      2'd0: ct_data_o = res_q[BLOCK_W-1          -: WORD_W];
      2'd1: ct_data_o = res_q[BLOCK_W-1-WORD_W   -: WORD_W];
      2'd2: ct_data_o = res_q[BLOCK_W-1-2*WORD_W -: WORD_W];
      2'd3: ct_data_o = res_q[BLOCK_W-1-3*WORD_W -: WORD_W];
      default: ct_data_o = '0;
    endcase
  end

  // Result register, word pointer and occupancy flag; a new result is only
  // taken once the previous one has fully drained, so the data stays stable.
  always_ff @(posedge clk) begin
    if (flush) begin
      res_q      <= '0;
      ct_idx_q   <= '0;
      res_full_q <= 1'b0;
    end else begin
      if (res_hs) begin
        res_q      <= res_data_i;
        res_full_q <= 1'b1;
        ct_idx_q   <= '0;
      end else if (ct_hs) begin
        ct_idx_q <= ct_idx_q + 2'd1;
        if (block_done_o) begin
          res_full_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/aes_block_gearbox.sv
// Width-conversion and job sequencing between the 32-bit HWPE streams and
// the 128-bit iterative AES core. Packs plaintext words into blocks, hands
// them to the core, and unpacks results through aes_block_serializer.
// BLOCK_W is expected to be exactly four times WORD_W.
module aes_block_gearbox
  import aes_package::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_blocks_i,
  input  logic               pt_valid_i,
  output logic               pt_ready_o,
  input  logic [WORD_W-1:0]  pt_data_i,
  output logic               core_valid_o,
  input  logic               core_ready_i,
  output logic [BLOCK_W-1:0] core_data_o,
  input  logic               res_valid_i,
  output logic               res_ready_o,
  input  logic [BLOCK_W-1:0] res_data_i,
  output logic               ct_valid_o,
  input  logic               ct_ready_i,
  output logic [WORD_W-1:0]  ct_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   blocks_done_o
);

  aes_gearbox_state_t state_q, state_d;

  logic               flush;
  logic [CNT_W-1:0]   n_blocks_q;
  logic [CNT_W-1:0]   blocks_issued_q;
  logic [CNT_W-1:0]   blocks_done_q;
  logic [1:0]         word_idx_q;
  logic               blk_full_q;
  logic [BLOCK_W-1:0] core_data_q;
  logic               pt_hs;
  logic               core_hs;
  logic               block_done;
  logic               last_block_done;
  logic               job_start;

  assign flush           = reset | clear;
  assign job_start       = (state_q == IDLE) & start;
  assign pt_ready_o      = (state_q == RUN) & enable & ~blk_full_q &
                           (blocks_issued_q < n_blocks_q);
  assign pt_hs           = pt_valid_i & pt_ready_o;
  assign core_valid_o    = blk_full_q;
  assign core_hs         = blk_full_q & core_ready_i;
  assign core_data_o     = core_data_q;
  assign last_block_done = block_done & ((blocks_done_q + CNT_W'(1)) == n_blocks_q);
  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign blocks_done_o   = blocks_done_q;

  // Job FSM state register; clear acts exactly like reset and beats start.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: an empty job goes straight to DONE for its pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (n_blocks_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_block_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pack path and job counters; a job start rearms the counters while
  // blocks_done stays visible after the job until the next start.
  always_ff @(posedge clk) begin
    if (flush) begin
      n_blocks_q      <= '0;
      blocks_issued_q <= '0;
      blocks_done_q   <= '0;
      word_idx_q      <= '0;
      blk_full_q      <= 1'b0;
      core_data_q     <= '0;
    end else if (job_start) begin
      n_blocks_q      <= n_blocks_i;
      blocks_issued_q <= '0;
      blocks_done_q   <= '0;
      word_idx_q      <= '0;
      blk_full_q      <= 1'b0;
    end else begin
      if (pt_hs) begin
        unique case (word_idx_q)
          2'd0: core_data_q[BLOCK_W-1          -: WORD_W] <= pt_data_i;
          2'd1: core_data_q[BLOCK_W-1-WORD_W   -: WORD_W] <= pt_data_i;
          2'd2: core_data_q[BLOCK_W-1-2*WORD_W -: WORD_W] <= pt_data_i;
          2'd3: core_data_q[BLOCK_W-1-3*WORD_W -: WORD_W] <= pt_data_i;
          default: core_data_q <= core_data_q;
        endcase
        word_idx_q <= word_idx_q + 2'd1;
        if (word_idx_q == 2'(AES_WORDS_PER_BLOCK - 1)) begin
          blk_full_q <= 1'b1;
        end
      end
      if (core_hs) begin
        blk_full_q      <= 1'b0;
        blocks_issued_q <= blocks_issued_q + CNT_W'(1);
        word_idx_q      <= '0;
      end
      if (block_done) begin
        blocks_done_q <= blocks_done_q + CNT_W'(1);
      end
    end
  end

  aes_block_serializer #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_serializer (
    .clk          (clk),
    .flush        (flush),
    .accept_en    ((state_q == RUN) & enable),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .res_data_i   (res_data_i),
    .ct_valid_o   (ct_valid_o),
    .ct_ready_i   (ct_ready_i),
    .ct_data_o    (ct_data_o),
    .block_done_o (block_done)
  );

endmodule
